// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser: pays a return amount back out largest-coin-first,
// one coin per ejection handshake, while tracking per-denomination tube stock.
// Any amount that cannot be covered is reported as a shortfall.
module coin_change_dispenser #(
  parameter int kNumCoins  = 3,
  parameter int kTotalBits = 31,
  parameter int COIN_VAL0  = 100,
  parameter int COIN_VAL1  = 500,
  parameter int COIN_VAL2  = 1000,
  parameter int CNT_BITS   = 8,
  parameter int INIT_COUNT = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic [kTotalBits-1:0]         i_amount,
  input  logic [kNumCoins-1:0]          i_refill,
  input  logic                          i_mech_ready,
  output logic [kNumCoins-1:0]          o_return_coin,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [kTotalBits-1:0]         o_shortfall,
  output logic                          o_error,
  output logic [kNumCoins*CNT_BITS-1:0] o_tube_count
);

  localparam int SEL_W = (kNumCoins > 1) ? $clog2(kNumCoins) : 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [kTotalBits-1:0] remaining_q, remaining_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [kNumCoins-1:0]  coin_q, coin_d;
  logic                  done_q, done_d;
  logic [kTotalBits-1:0] shortfall_q, shortfall_d;
  logic [CNT_BITS-1:0]   cnt_q [kNumCoins];

  logic                  pick_found;
  logic [SEL_W-1:0]      pick_idx;
  logic                  fire;

  // Face value of denomination k; unknown indices are worth nothing and are
  // never selected.
  function automatic logic [kTotalBits-1:0] coin_val(input int k);
    case (k)
      0:       coin_val = kTotalBits'(COIN_VAL0);
      1:       coin_val = kTotalBits'(COIN_VAL1);
      2:       coin_val = kTotalBits'(COIN_VAL2);
      default: coin_val = '0;
    endcase
  endfunction

  // A coin leaves the machine when the mechanism takes the presented coin.
  assign fire = (state_q == DISPENSE) && i_mech_ready;

  // Greedy pick: the largest stocked coin that still fits the remainder.
  // Re-evaluated from live counts, so a refill can re-enable a larger coin.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      if ((coin_val(k) != '0) && (coin_val(k) <= remaining_q) &&
          (cnt_q[k] != '0)) begin
        pick_found = 1'b1;
        pick_idx   = SEL_W'(k);
      end
    end
  end

  // State register; reset aborts any request and drops the coin at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (i_start) state_d = SELECT;
      SELECT:   state_d = pick_found ? DISPENSE : DONE;
      DISPENSE: if (i_mech_ready) state_d = SELECT;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    remaining_d = remaining_q;
    sel_d       = sel_q;
    coin_d      = coin_q;
    shortfall_d = shortfall_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) remaining_d = i_amount;
      end
      SELECT: begin
        if (pick_found) begin
          sel_d  = pick_idx;
          coin_d = kNumCoins'(1) << pick_idx;
        end else begin
          // Nothing more can be paid: whatever is left is the shortfall.
          shortfall_d = remaining_q;
          done_d      = 1'b1;
        end
      end
      DISPENSE: begin
        if (i_mech_ready) begin
          // The pick guaranteed coin_val(sel) <= remaining, so no underflow.
          remaining_d = remaining_q - coin_val(int'(sel_q));
          coin_d      = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_q <= '0;
      sel_q       <= '0;
      coin_q      <= '0;
      done_q      <= 1'b0;
      shortfall_q <= '0;
    end else begin
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
      coin_q      <= coin_d;
      done_q      <= done_d;
      shortfall_q <= shortfall_d;
    end
  end

  // Tube inventory: saturating refill, decrement on each ejected coin; a
  // refill and an ejection of the same tube on one edge cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the tube counters are architectural state (the machine's stock
      // after power-up), so unlike a data memory they are reset explicitly.
      for (int k = 0; k < kNumCoins; k++) cnt_q[k] <= CNT_BITS'(INIT_COUNT);
    end else begin
      for (int k = 0; k < kNumCoins; k++) begin
        if (i_refill[k] && fire && (int'(sel_q) == k)) begin
          cnt_q[k] <= cnt_q[k];
        end else if (i_refill[k]) begin
          if (cnt_q[k] != CNT_MAX) cnt_q[k] <= cnt_q[k] + 1'b1;
        end else if (fire && (int'(sel_q) == k)) begin
          cnt_q[k] <= cnt_q[k] - 1'b1;
        end
      end
    end
  end

  assign o_return_coin = coin_q;
  assign o_done        = done_q;
  assign o_shortfall   = shortfall_q;
  assign o_busy        = (state_q != IDLE);
  assign o_error       = (shortfall_q != '0);

  for (genvar g = 0; g < kNumCoins; g++) begin : g_tube
    assign o_tube_count[g*CNT_BITS +: CNT_BITS] = cnt_q[g];
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// tb_coin_change_dispenser: directed vectors with hand-computed expectations
// for the coin-return dispenser.
module tb_coin_change_dispenser;

  localparam int NC = 3;
  localparam int TB = 31;
  localparam int CB = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_start;
  logic [TB-1:0]  i_amount;
  logic [NC-1:0]  i_refill;
  logic           i_mech_ready;
  logic [NC-1:0]  o_return_coin;
  logic           o_busy;
  logic           o_done;
  logic [TB-1:0]  o_shortfall;
  logic           o_error;
  logic [NC*CB-1:0] o_tube_count;

  int n_checks = 0;
  int n_pass   = 0;
  int edges;
  bit timed_out;
  logic [NC-1:0] got_q[$];
  logic [NC-1:0] exp_q[$];

  coin_change_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_amount     (i_amount),
    .i_refill     (i_refill),
    .i_mech_ready (i_mech_ready),
    .o_return_coin(o_return_coin),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_shortfall  (o_shortfall),
    .o_error      (o_error),
    .o_tube_count (o_tube_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CB-1:0] tube(input int k);
    return o_tube_count[k*CB +: CB];
  endfunction

  // Issue a request with the mechanism always ready and record every coin
  // presented; edges counts the start edge as 1.
  task automatic run_req(input logic [TB-1:0] amt);
    i_amount = amt;
    i_start  = 1'b1;
    tick();
    i_start   = 1'b0;
    edges     = 1;
    timed_out = 1'b0;
    got_q.delete();
    while (o_done !== 1'b1) begin
      if (o_return_coin != '0) got_q.push_back(o_return_coin);
      if (edges >= 200) begin
        timed_out = 1'b1;
        break;
      end
      tick();
      edges++;
    end
    check("done_seen", timed_out, 0);
  endtask

  task automatic check_coins(input string tag);
    check({tag, "_ncoins"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_coin"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    bit stable;
    reset        = 1'b1;
    i_start      = 1'b0;
    i_amount     = '0;
    i_refill     = '0;
    i_mech_ready = 1'b1;
    #1;
    check("rst_coin", o_return_coin, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_short", o_shortfall, 0);
    check("rst_err", o_error, 0);
    check("rst_tubes", o_tube_count, {8'd10, 8'd10, 8'd10});
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Full tubes, exact change: 1600 = 1000 + 500 + 100.
    exp_q = '{3'b100, 3'b010, 3'b001};
    run_req(1600);
    check_coins("exact");
    check("exact_latency", edges, 8);
    check("exact_done", o_done, 1);
    check("exact_short", o_shortfall, 0);
    check("exact_err", o_error, 0);
    check("exact_tubes", o_tube_count, {8'd9, 8'd9, 8'd9});
    tick();
    check("exact_done_pulse", o_done, 0);
    check("exact_busy_fall", o_busy, 0);

    // Zero amount goes straight through SELECT to DONE.
    exp_q = {};
    run_req(0);
    check_coins("zero");
    check("zero_latency", edges, 2);
    check("zero_short", o_shortfall, 0);
    tick();

    // Empty tube 2 with nine more single 1000 payouts.
    exp_q = '{3'b100};
    for (int i = 0; i < 9; i++) begin
      run_req(1000);
      check_coins("drain");
      tick();
    end
    check("drain_tube2", tube(2), 0);

    // Tube shortage: 2000 must come out as four 500 coins.
    exp_q = '{3'b010, 3'b010, 3'b010, 3'b010};
    run_req(2000);
    check_coins("short_tube");
    check("short_tube_latency", edges, 10);
    check("short_tube_short", o_shortfall, 0);
    check("short_tube_t1", tube(1), 5);
    check("short_tube_t0", tube(0), 9);
    tick();

    // Uncoverable remainder: 650 -> 500 + 100, 50 left over.
    exp_q = '{3'b010, 3'b001};
    run_req(650);
    check_coins("uncov");
    check("uncov_short", o_shortfall, 50);
    check("uncov_err", o_error, 1);
    check("uncov_tubes", o_tube_count, {8'd0, 8'd4, 8'd8});
    tick();
    check("uncov_short_hold", o_shortfall, 50);

    // Simultaneous refill and dispense of tube 1, plus a start while busy.
    i_mech_ready = 1'b0;
    i_amount     = 500;
    i_start      = 1'b1;
    tick();
    check("sim_busy_rise", o_busy, 1);
    i_start = 1'b0;
    tick();
    check("sim_coin", o_return_coin, 3'b010);
    i_refill     = 3'b010;
    i_mech_ready = 1'b1;
    i_start      = 1'b1;
    i_amount     = 100;
    tick();
    i_refill = '0;
    i_start  = 1'b0;
    check("sim_t1_unchanged", tube(1), 4);
    check("sim_coin_drop", o_return_coin, 0);
    tick();
    check("sim_done", o_done, 1);
    check("sim_short", o_shortfall, 0);
    tick();
    tick();
    check("sim_start_ignored", o_busy, 0);
    check("sim_t0_unchanged", tube(0), 8);

    // Non-one-hot refill bumps every asserted tube.
    i_refill = 3'b101;
    tick();
    i_refill = '0;
    check("refill_multi", o_tube_count, {8'd1, 8'd4, 8'd9});

    // Tube 1 saturates at 255.
    i_refill = 3'b010;
    for (int i = 0; i < 300; i++) tick();
    i_refill = '0;
    check("refill_sat", tube(1), 255);

    // Async reset while coin 2 is presented.
    i_mech_ready = 1'b0;
    i_amount     = 1000;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    check("arst_coin_before", o_return_coin, 3'b100);
    #2;
    reset = 1'b1;
    #1;
    check("arst_coin", o_return_coin, 0);
    check("arst_busy", o_busy, 0);
    check("arst_done", o_done, 0);
    check("arst_short", o_shortfall, 0);
    check("arst_tubes", o_tube_count, {8'd10, 8'd10, 8'd10});
    tick();
    tick();
    check("arst_no_done", o_done, 0);
    reset = 1'b0;
    tick();

    // Handshake stall after reset: coin held until the first ready edge.
    i_amount = 100;
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    stable = (o_return_coin == 3'b001);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_return_coin != 3'b001) stable = 1'b0;
    end
    check("stall_hold", stable, 1);
    check("stall_t0_held", tube(0), 10);
    i_mech_ready = 1'b1;
    tick();
    check("stall_consumed", o_return_coin, 0);
    check("stall_t0", tube(0), 9);
    tick();
    check("stall_done", o_done, 1);
    check("stall_short", o_shortfall, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
